// File: rtl/tile_draw_scheduler_pkg.sv
// tile_sched_pkg: shared types and constants for the tile draw scheduler.
//   state_e  - scheduler FSM states
//   status_e - completion codes returned with each ack
//   REQ_BG / REQ_SP - requester IDs (also the arbiter grant_id encoding)
//   tile_base() - tile index to ROM byte address (index * 192)
package tile_sched_pkg;

  localparam int TILE_BYTES    = 192;
  localparam int NUM_TILES     = 21;
  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;
  localparam int START_TIMEOUT = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    ACK
  } state_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_BAD_TILE  = 2'b01,
    ST_OFFSCREEN = 2'b10,
    ST_TIMEOUT   = 2'b11
  } status_e;

  localparam logic REQ_BG = 1'b0;
  localparam logic REQ_SP = 1'b1;

  // 192 = 128 + 64, so the product is two shifted copies of the index.
  function automatic logic [11:0] tile_base(input logic [4:0] tile);
    return ({7'd0, tile} << 7) + ({7'd0, tile} << 6);
  endfunction

endpackage

// File: rtl/tile_draw_scheduler_if.sv
// tile_draw_scheduler_if: requester and drawer signals of the scheduler.
//   bg_* / sp_*  - request, operands and ack of the two requesters
//   status       - completion code, meaningful only while an ack is high
//   drw_*        - draw pulse, operands and busy of the shared tile drawer
//   sched_busy   - scheduler is not idle
// slave modport: scheduler side.  master modport: requesters + drawer side.
interface tile_draw_scheduler_if;
  logic        bg_req;
  logic [4:0]  bg_tile;
  logic [7:0]  bg_x;
  logic [7:0]  bg_y;
  logic        bg_ack;
  logic        sp_req;
  logic [4:0]  sp_tile;
  logic [7:0]  sp_x;
  logic [7:0]  sp_y;
  logic        sp_ack;
  logic [1:0]  status;
  logic        drw_draw;
  logic [11:0] drw_tile_base;
  logic [7:0]  drw_x;
  logic [7:0]  drw_y;
  logic        drw_busy;
  logic        sched_busy;

  modport slave (
    input  bg_req, bg_tile, bg_x, bg_y, sp_req, sp_tile, sp_x, sp_y, drw_busy,
    output bg_ack, sp_ack, status, drw_draw, drw_tile_base, drw_x, drw_y, sched_busy
  );

  modport master (
    output bg_req, bg_tile, bg_x, bg_y, sp_req, sp_tile, sp_x, sp_y, drw_busy,
    input  bg_ack, sp_ack, status, drw_draw, drw_tile_base, drw_x, drw_y, sched_busy
  );
endinterface

// File: rtl/tile_draw_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, resetn - clock, asynchronous active-low reset
//   req[1:0]    - bit 0 = bg, bit 1 = sp
//   advance     - commit the current grant and move the pointer
//   grant[1:0]  - one-hot grant (zero when nothing is requested)
//   grant_id    - index of the granted requester
// The pointer holds the ID that wins a tie; it resets to bg.
module rr_arbiter2
  import tile_sched_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_id = REQ_BG;
    if (req == 2'b11) begin
      grant_id = ptr_q;
    end else if (req[1]) begin
      grant_id = REQ_SP;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = (grant_id == REQ_SP) ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (advance && (req != 2'b00)) begin
      ptr_d = ~grant_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= REQ_BG;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tile_draw_scheduler.sv
// tile_draw_scheduler: shares one tile drawer between the background walker
// (bg) and the sprite engine (sp).
//   clk, resetn - clock, asynchronous active-low reset
//   bus (slave) - requester handshakes, status, drawer operands/handshake
// Flow: IDLE grant -> CHECK latch + validate -> ISSUE draw pulse ->
// WAIT_START (bounded) -> WAIT_DONE -> ACK one-cycle pulse -> IDLE.
module tile_draw_scheduler
  import tile_sched_pkg::*;
#(
  parameter int SCREEN_W      = tile_sched_pkg::SCREEN_W,
  parameter int SCREEN_H      = tile_sched_pkg::SCREEN_H,
  parameter int START_TIMEOUT = tile_sched_pkg::START_TIMEOUT
) (
  input logic                  clk,
  input logic                  resetn,
  tile_draw_scheduler_if.slave bus
);

  localparam logic [4:0] TILE_LIMIT = 5'(NUM_TILES);
  localparam logic [7:0] X_MAX      = 8'(SCREEN_W - 8);
  localparam logic [7:0] Y_MAX      = 8'(SCREEN_H - 8);
  localparam logic [2:0] TMO_LAST   = 3'(START_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  timer_q, timer_d;
  logic        gnt_id_q, gnt_id_d;
  status_e     status_q, status_d;
  logic [4:0]  tile_q, tile_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;

  logic [1:0]  req;
  logic [1:0]  grant;
  logic        grant_id;
  logic        advance;
  logic [4:0]  sel_tile;
  logic [7:0]  sel_x;
  logic [7:0]  sel_y;
  logic        drive_ops;

  assign req = {bus.sp_req, bus.bg_req};

  rr_arbiter2 u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_tile = (gnt_id_q == REQ_SP) ? bus.sp_tile : bus.bg_tile;
  assign sel_x    = (gnt_id_q == REQ_SP) ? bus.sp_x    : bus.bg_x;
  assign sel_y    = (gnt_id_q == REQ_SP) ? bus.sp_y    : bus.bg_y;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gnt_id_d = gnt_id_q;
    status_d = status_q;
    tile_d   = tile_q;
    x_d      = x_q;
    y_d      = y_q;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          advance  = 1'b1;
          gnt_id_d = grant_id;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        tile_d = sel_tile;
        x_d    = sel_x;
        y_d    = sel_y;
        if (sel_tile >= TILE_LIMIT) begin
          status_d = ST_BAD_TILE;
          state_d  = ACK;
        end else if ((sel_x > X_MAX) || (sel_y > Y_MAX)) begin
          status_d = ST_OFFSCREEN;
          state_d  = ACK;
        end else begin
          status_d = ST_OK;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = 3'd0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        // Busy is honoured even on the last allowed cycle.
        if (bus.drw_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMO_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = ACK;
        end else begin
          timer_d = timer_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.drw_busy) begin
          status_d = ST_OK;
          state_d  = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      timer_q  <= 3'd0;
      gnt_id_q <= REQ_BG;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  always_ff @(posedge clk) begin
    status_q <= status_d;
    tile_q   <= tile_d;
    x_q      <= x_d;
    y_q      <= y_d;
  end

  // Outputs decode from the state register alone, so reset clears them at once.
  assign drive_ops = (state_q == ISSUE) || (state_q == WAIT_START) || (state_q == WAIT_DONE);

  assign bus.drw_draw      = (state_q == ISSUE);
  assign bus.drw_tile_base = drive_ops ? tile_base(tile_q) : 12'd0;
  assign bus.drw_x         = drive_ops ? x_q : 8'd0;
  assign bus.drw_y         = drive_ops ? y_q : 8'd0;
  assign bus.bg_ack        = (state_q == ACK) && (gnt_id_q == REQ_BG);
  assign bus.sp_ack        = (state_q == ACK) && (gnt_id_q == REQ_SP);
  assign bus.status        = (state_q == ACK) ? status_q : ST_OK;
  assign bus.sched_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Bench for tile_draw_scheduler: table vectors, hand-written corner sequences
// and randomized jobs checked against a behavioural model.
module tb_tile_draw_scheduler;

  localparam int M_TILES   = 21;
  localparam int M_X_MAX   = 152;
  localparam int M_Y_MAX   = 112;
  localparam int M_TIMEOUT = 4;

  logic clk = 1'b0;
  logic resetn;

  tile_draw_scheduler_if bus ();

  tile_draw_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drawer model: busy rises drw_delay cycles after the draw pulse, lasts drw_hold cycles.
  int   drw_delay = 2;
  int   drw_hold  = 100;
  bit   drw_never = 1'b0;
  logic busy_r;
  int   pend;
  int   hold_cnt;

  assign bus.drw_busy = busy_r;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r   <= 1'b0;
      pend     <= 0;
      hold_cnt <= 0;
    end else if (bus.drw_draw && !drw_never) begin
      if (drw_delay == 0) begin
        busy_r   <= 1'b1;
        hold_cnt <= drw_hold;
      end else begin
        pend <= drw_delay;
      end
    end else if (pend > 0) begin
      if (pend == 1) begin
        busy_r   <= 1'b1;
        hold_cnt <= drw_hold;
      end
      pend <= pend - 1;
    end else if (busy_r) begin
      if (hold_cnt <= 1) busy_r <= 1'b0;
      else hold_cnt <= hold_cnt - 1;
    end
  end

  // Monitor: draw pulses, operands captured at the pulse, operand stability, busy fall.
  int          draw_cnt   = 0;
  int          draw_cyc   = 0;
  int          fall_cyc   = 0;
  int          stable_err = 0;
  logic [11:0] cap_base   = '0;
  logic [7:0]  cap_x      = '0;
  logic [7:0]  cap_y      = '0;
  logic        prev_busy  = 1'b0;

  always @(negedge clk) begin
    if (bus.drw_draw) begin
      draw_cnt <= draw_cnt + 1;
      draw_cyc <= cyc;
      cap_base <= bus.drw_tile_base;
      cap_x    <= bus.drw_x;
      cap_y    <= bus.drw_y;
    end else if (bus.drw_busy && ((bus.drw_tile_base != cap_base) ||
                                  (bus.drw_x != cap_x) || (bus.drw_y != cap_y))) begin
      stable_err <= stable_err + 1;
    end
    if (prev_busy && !bus.drw_busy) fall_cyc <= cyc;
    prev_busy <= bus.drw_busy;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  // Behavioural model
  int last_served = 1;  // after reset bg wins a tie

  function automatic int model_status(input int t, input int x, input int y, input bit started);
    if (t >= M_TILES) return 1;
    if ((x > M_X_MAX) || (y > M_Y_MAX)) return 2;
    return started ? 0 : 3;
  endfunction

  function automatic int model_base(input int t);
    return t * 192;
  endfunction

  function automatic int tie_winner();
    return (last_served == 0) ? 1 : 0;
  endfunction

  task automatic drive_req(input bit who, input logic [4:0] t, input logic [7:0] x,
                           input logic [7:0] y);
    if (who == 1'b0) begin
      bus.bg_tile = t; bus.bg_x = x; bus.bg_y = y; bus.bg_req = 1'b1;
    end else begin
      bus.sp_tile = t; bus.sp_x = x; bus.sp_y = y; bus.sp_req = 1'b1;
    end
  endtask

  task automatic do_job(input bit who, input logic [4:0] t, input logic [7:0] x,
                        input logic [7:0] y, input bit hold_req, input bit alter,
                        output int st, output int ack_who, output int ndraw,
                        output int req_cyc, output int ack_cyc);
    int d0;
    bit seen;
    d0 = draw_cnt;
    @(posedge clk); #1;
    req_cyc = cyc;
    drive_req(who, t, x, y);
    seen = 1'b0; st = -1; ack_who = -1; ack_cyc = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (alter && bus.drw_busy) begin
        if (who == 1'b0) bus.bg_x = ~x;
        else bus.sp_x = ~x;
      end
      if (bus.bg_ack || bus.sp_ack) begin
        seen    = 1'b1;
        st      = int'(bus.status);
        ack_who = (bus.bg_ack && bus.sp_ack) ? 2 : (bus.sp_ack ? 1 : 0);
        ack_cyc = cyc;
      end
    end
    check("ack_arrived", int'(seen), 1);
    ndraw = draw_cnt - d0;
    @(posedge clk); #1;
    if (!hold_req) begin
      if (who == 1'b0) bus.bg_req = 1'b0;
      else bus.sp_req = 1'b0;
    end
    @(negedge clk);
    check("ack_one_pulse", int'(bus.bg_ack | bus.sp_ack), 0);
    if (!hold_req) check("idle_after_ack", int'(bus.sched_busy), 0);
  endtask

  task automatic do_pair(input logic [4:0] tb_t, input logic [7:0] xb, input logic [7:0] yb,
                         input logic [4:0] ts, input logic [7:0] xs, input logic [7:0] ys,
                         output int first, output int second,
                         output int st_first, output int st_second);
    int got;
    int w;
    got = 0; first = -1; second = -1; st_first = -1; st_second = -1;
    @(posedge clk); #1;
    drive_req(1'b0, tb_t, xb, yb);
    drive_req(1'b1, ts, xs, ys);
    for (int i = 0; i < 4000 && got < 2; i++) begin
      @(negedge clk);
      if (bus.bg_ack || bus.sp_ack) begin
        w = bus.sp_ack ? 1 : 0;
        if (got == 0) begin first = w; st_first = int'(bus.status); end
        else begin second = w; st_second = int'(bus.status); end
        got++;
        @(posedge clk); #1;
        if (w == 0) bus.bg_req = 1'b0;
        else bus.sp_req = 1'b0;
      end
    end
    check("pair_acks", got, 2);
  endtask

  typedef struct {
    bit         who;
    logic [4:0] t;
    logic [7:0] x;
    logic [7:0] y;
    bit         never;
    int         exp_st;
    int         exp_base;
    int         exp_draws;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st, aw, nd, rc, ac, se0, d;
    int f, s, sf, ss, w;
    logic [4:0] t0, t1;
    logic [7:0] x0, y0, x1, y1;
    bit reached;

    vecs[0] = '{1'b0, 5'd3,  8'd16,  8'd8,   1'b0, 0, 576,  1};
    vecs[1] = '{1'b1, 5'd21, 8'd0,   8'd0,   1'b0, 1, 0,    0};
    vecs[2] = '{1'b1, 5'd20, 8'd153, 8'd0,   1'b0, 2, 0,    0};
    vecs[3] = '{1'b1, 5'd20, 8'd152, 8'd112, 1'b0, 0, 3840, 1};
    vecs[4] = '{1'b0, 5'd31, 8'd200, 8'd200, 1'b0, 1, 0,    0};
    vecs[5] = '{1'b0, 5'd0,  8'd0,   8'd113, 1'b0, 2, 0,    0};
    vecs[6] = '{1'b1, 5'd5,  8'd10,  8'd10,  1'b1, 3, 960,  1};
    vecs[7] = '{1'b0, 5'd0,  8'd0,   8'd0,   1'b0, 0, 0,    1};

    bus.bg_req = 0; bus.bg_tile = 0; bus.bg_x = 0; bus.bg_y = 0;
    bus.sp_req = 0; bus.sp_tile = 0; bus.sp_x = 0; bus.sp_y = 0;
    resetn = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bg_ack", int'(bus.bg_ack), 0);
    check("rst_sp_ack", int'(bus.sp_ack), 0);
    check("rst_status", int'(bus.status), 0);
    check("rst_draw", int'(bus.drw_draw), 0);
    check("rst_base", int'(bus.drw_tile_base), 0);
    check("rst_x", int'(bus.drw_x), 0);
    check("rst_y", int'(bus.drw_y), 0);
    check("rst_sched_busy", int'(bus.sched_busy), 0);
    resetn = 1'b1;

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      drw_never = vecs[v].never; drw_delay = 2; drw_hold = 100;
      se0 = stable_err;
      do_job(vecs[v].who, vecs[v].t, vecs[v].x, vecs[v].y, 1'b0, 1'b0, st, aw, nd, rc, ac);
      last_served = vecs[v].who;
      check($sformatf("vec%0d_status", v), st, vecs[v].exp_st);
      check($sformatf("vec%0d_ack_who", v), aw, int'(vecs[v].who));
      check($sformatf("vec%0d_draws", v), nd, vecs[v].exp_draws);
      check($sformatf("vec%0d_stable", v), stable_err - se0, 0);
      if (vecs[v].exp_draws == 1) begin
        check($sformatf("vec%0d_draw_lat", v), draw_cyc - rc, 2);
        check($sformatf("vec%0d_base", v), int'(cap_base), vecs[v].exp_base);
        check($sformatf("vec%0d_x", v), int'(cap_x), int'(vecs[v].x));
        check($sformatf("vec%0d_y", v), int'(cap_y), int'(vecs[v].y));
      end else begin
        check($sformatf("vec%0d_reject_lat", v), ac - rc, 2);
      end
      if (vecs[v].exp_st == 0) check($sformatf("vec%0d_ack_after_fall", v), ac - fall_cyc, 1);
      if (vecs[v].exp_st == 3) begin
        d = ac - draw_cyc;
        check($sformatf("vec%0d_timeout_window", v),
              int'((d >= M_TIMEOUT) && (d <= 1 + M_TIMEOUT + 1)), 1);
      end
    end
    drw_never = 1'b0;

    // Fresh reset, then simultaneous requests alternate
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    last_served = 1;
    drw_delay = 1; drw_hold = 10;
    for (int r = 0; r < 2; r++) begin
      do_pair(5'd1, 8'd0, 8'd0, 5'd2, 8'd8, 8'd8, f, s, sf, ss);
      check($sformatf("tie%0d_first", r), f, tie_winner());
      check($sformatf("tie%0d_second", r), s, 1 - tie_winner());
      check($sformatf("tie%0d_st1", r), sf, 0);
      check($sformatf("tie%0d_st2", r), ss, 0);
      last_served = s;
    end

    // Asynchronous reset during WAIT_DONE
    drw_delay = 2; drw_hold = 200;
    @(posedge clk); #1;
    drive_req(1'b0, 5'd7, 8'd8, 8'd8);
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (bus.sched_busy && bus.drw_busy) reached = 1'b1;
    end
    check("rst_mid_reached", int'(reached), 1);
    check("rst_mid_base_before", int'(bus.drw_tile_base), 1344);
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_base", int'(bus.drw_tile_base), 0);
    check("rst_mid_x", int'(bus.drw_x), 0);
    check("rst_mid_sched_busy", int'(bus.sched_busy), 0);
    bus.bg_req = 1'b0;
    w = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.bg_ack || bus.sp_ack) w++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.bg_ack || bus.sp_ack) w++;
    end
    check("rst_mid_no_ack", w, 0);
    last_served = 1;
    drw_hold = 10;
    do_pair(5'd4, 8'd0, 8'd0, 5'd6, 8'd0, 8'd0, f, s, sf, ss);
    check("rst_mid_tie_first", f, tie_winner());
    check("rst_mid_tie_st", sf, 0);
    last_served = s;

    // Operand change after grant has no effect
    drw_delay = 2; drw_hold = 30;
    se0 = stable_err;
    do_job(1'b0, 5'd3, 8'd40, 8'd24, 1'b0, 1'b1, st, aw, nd, rc, ac);
    last_served = 0;
    check("alter_x", int'(cap_x), 40);
    check("alter_stable", stable_err - se0, 0);
    check("alter_status", st, 0);

    // Request held past ack issues a second identical draw
    do_job(1'b0, 5'd4, 8'd16, 8'd16, 1'b1, 1'b0, st, aw, nd, rc, ac);
    check("held1_draws", nd, 1);
    check("held1_status", st, 0);
    do_job(1'b0, 5'd4, 8'd16, 8'd16, 1'b0, 1'b0, st, aw, nd, rc, ac);
    check("held2_draws", nd, 1);
    check("held2_base", int'(cap_base), 768);
    check("held2_status", st, 0);
    last_served = 0;

    // Randomized jobs
    for (int it = 0; it < 24; it++) begin
      w  = int'($urandom_range(0, 2));
      t0 = 5'($urandom_range(0, 23)); x0 = 8'($urandom_range(0, 170)); y0 = 8'($urandom_range(0, 130));
      t1 = 5'($urandom_range(0, 23)); x1 = 8'($urandom_range(0, 170)); y1 = 8'($urandom_range(0, 130));
      drw_never = ($urandom_range(0, 7) == 0);
      drw_delay = int'($urandom_range(0, 2));
      drw_hold  = int'($urandom_range(1, 30));
      if (w < 2) begin
        do_job(w[0], t0, x0, y0, 1'b0, 1'b0, st, aw, nd, rc, ac);
        check($sformatf("rnd%0d_status", it), st, model_status(t0, x0, y0, !drw_never));
        check($sformatf("rnd%0d_who", it), aw, w);
        d = model_status(t0, x0, y0, !drw_never);
        check($sformatf("rnd%0d_draws", it), nd, ((d == 0) || (d == 3)) ? 1 : 0);
        if (nd == 1) check($sformatf("rnd%0d_base", it), int'(cap_base), model_base(t0));
        last_served = w;
      end else begin
        do_pair(t0, x0, y0, t1, x1, y1, f, s, sf, ss);
        check($sformatf("rnd%0d_first", it), f, tie_winner());
        if (f == 0) begin
          check($sformatf("rnd%0d_st_bg", it), sf, model_status(t0, x0, y0, !drw_never));
          check($sformatf("rnd%0d_st_sp", it), ss, model_status(t1, x1, y1, !drw_never));
        end else begin
          check($sformatf("rnd%0d_st_sp", it), sf, model_status(t1, x1, y1, !drw_never));
          check($sformatf("rnd%0d_st_bg", it), ss, model_status(t0, x0, y0, !drw_never));
        end
        last_served = s;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
